// File: rtl/parking_occupancy_counter.sv
// Parking occupancy counter.
// Two gate sensors are synchronized and debounced. A sequence FSM then
// decides which way each car passed. The occupancy is held as two BCD
// digits that saturate at 0 and CAPACITY, and is shown on two active-low
// 7-segment patterns (seg1 is blank when the tens digit is zero).
module parking_occupancy_counter #(
    parameter int CAPACITY        = 20,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sens_a,
    input  logic       sens_b,
    output logic [6:0] count,
    output logic       full,
    output logic       empty,
    output logic       car_in,
    output logic       car_out,
    output logic       reject,
    output logic [6:0] seg0,
    output logic [6:0] seg1
);

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int             CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]     CAP     = 7'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, WAIT_CLR
    } state_e;

    logic [1:0] raw;   // {sens_a, sens_b}
    logic [1:0] ab;    // debounced {d_a, d_b}

    assign raw = {sens_a, sens_b};

    // Per-sensor conditioning: two-flop synchronizer followed by a debouncer
    // that accepts a new level only after it has been stable long enough.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            logic          sync1_q;
            logic          sync2_q;
            logic          deb_q;
            logic          deb_d;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Count consecutive disagreement cycles; any agreement clears the count.
            always_comb begin
                deb_d = deb_q;
                cnt_d = '0;
                if (sync2_q != deb_q) begin
                    if (cnt_q == DB_LAST) begin
                        deb_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            // Synchronizer, debounced level and counter registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw[gi];
                    sync2_q <= sync1_q;
                    deb_q   <= deb_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign ab[gi] = deb_q;
        end
    endgenerate

    state_e     state_q, state_d;
    logic       entry_done, exit_done;

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [6:0] count_q, count_d;
    logic       full_q, full_d;
    logic       empty_q, empty_d;
    logic       car_in_q, car_in_d;
    logic       car_out_q, car_out_d;
    logic       reject_q, reject_d;
    logic [6:0] seg0_q, seg0_d;
    logic [6:0] seg1_q, seg1_d;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Sequence FSM next state: forward steps advance, single steps back are
    // tolerated, anything else parks in WAIT_CLR until both sensors clear.
    always_comb begin
        state_d    = state_q;
        entry_done = 1'b0;
        exit_done  = 1'b0;
        case (state_q)
            IDLE: case (ab)
                2'b10:   state_d = EN_A;
                2'b01:   state_d = EX_B;
                2'b11:   state_d = WAIT_CLR;
                default: state_d = IDLE;
            endcase
            EN_A: case (ab)
                2'b11:   state_d = EN_AB;
                2'b00:   state_d = IDLE;
                2'b01:   state_d = WAIT_CLR;
                default: state_d = EN_A;
            endcase
            EN_AB: case (ab)
                2'b01:   state_d = EN_B;
                2'b10:   state_d = EN_A;
                2'b00:   state_d = WAIT_CLR;
                default: state_d = EN_AB;
            endcase
            EN_B: case (ab)
                2'b00: begin
                    state_d    = IDLE;
                    entry_done = 1'b1;
                end
                2'b11:   state_d = EN_AB;
                2'b10:   state_d = WAIT_CLR;
                default: state_d = EN_B;
            endcase
            EX_B: case (ab)
                2'b11:   state_d = EX_AB;
                2'b00:   state_d = IDLE;
                2'b10:   state_d = WAIT_CLR;
                default: state_d = EX_B;
            endcase
            EX_AB: case (ab)
                2'b10:   state_d = EX_A;
                2'b01:   state_d = EX_B;
                2'b00:   state_d = WAIT_CLR;
                default: state_d = EX_AB;
            endcase
            EX_A: case (ab)
                2'b00: begin
                    state_d   = IDLE;
                    exit_done = 1'b1;
                end
                2'b11:   state_d = EX_AB;
                2'b01:   state_d = WAIT_CLR;
                default: state_d = EX_A;
            endcase
            WAIT_CLR: state_d = (ab == 2'b00) ? IDLE : WAIT_CLR;
            default:  state_d = IDLE;
        endcase
    end

    // Saturating BCD count update and event pulses; the binary count tracks
    // the digits step for step so both stay equal to tens*10+ones.
    always_comb begin
        ones_d    = ones_q;
        tens_d    = tens_q;
        count_d   = count_q;
        car_in_d  = 1'b0;
        car_out_d = 1'b0;
        reject_d  = 1'b0;
        if (entry_done) begin
            if (count_q < CAP) begin
                car_in_d = 1'b1;
                count_d  = count_q + 7'd1;
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                reject_d = 1'b1;
            end
        end else if (exit_done) begin
            if (count_q != 7'd0) begin
                car_out_d = 1'b1;
                count_d   = count_q - 7'd1;
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end else begin
                reject_d = 1'b1;
            end
        end
        full_d  = (count_d == CAP);
        empty_d = (count_d == 7'd0);
    end

    // Segment patterns come from the registered digits, so they lag count by one cycle.
    always_comb begin
        seg0_d = seg7(ones_q);
        seg1_d = (tens_q == 4'd0) ? 7'b1111111 : seg7(tens_q);
    end

    // FSM state, count digits and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            count_q   <= 7'd0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            car_in_q  <= 1'b0;
            car_out_q <= 1'b0;
            reject_q  <= 1'b0;
            seg0_q    <= 7'b1000000;
            seg1_q    <= 7'b1111111;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            car_in_q  <= car_in_d;
            car_out_q <= car_out_d;
            reject_q  <= reject_d;
            seg0_q    <= seg0_d;
            seg1_q    <= seg1_d;
        end
    end

    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign car_in  = car_in_q;
    assign car_out = car_out_q;
    assign reject  = reject_q;
    assign seg0    = seg0_q;
    assign seg1    = seg1_q;

endmodule

// File: doc/parking_occupancy_counter.md
# parking_occupancy_counter

Upstream stage of the two-digit 7-segment display multiplexer in the vehicle-parking design. Debounces two gate sensors and decodes the direction of each passing car with a sequence FSM. Keeps a saturating two-digit BCD occupancy count and drives the ones (`seg0`) and tens (`seg1`) active-low 7-segment patterns consumed by the display mux, plus status flags.

## Interface

- `CAPACITY`, default 20: maximum occupancy; legal range 1..99.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a sensor change; minimum 1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `sens_a` in 1: outer gate sensor, active-high, asynchronous to `clk`.
- `sens_b` in 1: inner gate sensor, active-high, asynchronous to `clk`.
- `count` out 7: binary occupancy, 0..CAPACITY.
- `full` out 1: `count == CAPACITY`.
- `empty` out 1: `count == 0`.
- `car_in` out 1: one-cycle pulse when an accepted entry increments the count.
- `car_out` out 1: one-cycle pulse when an accepted exit decrements the count.
- `reject` out 1: one-cycle pulse when a completed entry at full or exit at empty is discarded.
- `seg0` out 7: ones digit, active-low, bit0=a … bit6=g.
- `seg1` out 7: tens digit, same encoding.

## Operation

**Input conditioning (per sensor)**
- 2-flop synchronizer, then debouncer.
- Debounced value `d` flips only after the synchronized value has differed from `d` for DEBOUNCE_CYCLES consecutive cycles.
- Any return to agreement clears the debounce counter.

**Sequence FSM**
- Input is `ab = {d_a, d_b}`. States: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, WAIT_CLR.
- Entry path: IDLE –10→ EN_A –11→ EN_AB –01→ EN_B –00→ IDLE, completing an entry.
- Exit path: IDLE –01→ EX_B –11→ EX_AB –10→ EX_A –00→ IDLE, completing an exit.
- Backtracking is legal and completes nothing:
  - EN_AB –10→ EN_A; EN_B –11→ EN_AB; EN_A –00→ IDLE.
  - EX_AB –01→ EX_B; EX_A –11→ EX_AB; EX_B –00→ IDLE.
- Unchanged `ab` holds the state.
- Any other transition goes to WAIT_CLR, e.g. IDLE on 11, or EN_A on 01.
- WAIT_CLR goes to IDLE on 00 with no count change.

**Counting**
- Completed entry: if count < CAPACITY, count+1 and pulse `car_in`; otherwise count holds and pulse `reject`.
- Completed exit: if count > 0, count−1 and pulse `car_out`; otherwise count holds and pulse `reject`.
- Count never wraps. At most one event per cycle, by FSM construction.
- Internally the count is held as two BCD digits with digit carry/borrow. `count` is the binary equivalent, tens×10 + ones.

**7-segment encoding (active-low gfedcba)**
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- `seg1` blanks to 1111111 when tens = 0 (leading-zero suppression). `seg0` is never blanked.

## Timing

**Reset values**
- All outputs reset asynchronously on `rst_n` low: count=0, full=0, empty=1, car_in/car_out/reject=0, seg0=1000000, seg1=1111111.
- FSM resets to IDLE; synchronizers, debounced values and debounce counters reset to 0.
- Reset mid-sequence discards the partial sequence.
- After reset release, sensors already high are seen as a 0→1 change and are debounced normally.

**Latency**
- Raw sensor edge to `d` change: 2 + DEBOUNCE_CYCLES cycles.
- FSM state registers on the edge after `d` changes.
- Final `d`=00 with the FSM in EN_B or EX_A: the next edge updates the FSM to IDLE, count, full/empty and the pulse together.
- `seg0`/`seg1` are registered from the count digits and update one cycle after `count`.

**Other rules**
- All outputs are registered; there are no combinational input-to-output paths.
- Glitches shorter than DEBOUNCE_CYCLES never reach the FSM.

## Test plan

Simulate with `DEBOUNCE_CYCLES`=4 and `CAPACITY`=3 unless stated.

1. Reset: hold `rst_n`=0 with sensors toggling → count=0, empty=1, seg0=1000000, seg1=1111111, no pulses.
2. Entry: `ab` 00→10→11→01→00, each held 10 cycles → one `car_in` pulse, count=1, seg0=1111001. Repeat twice more → count=3, full=1. A fourth entry → `reject` pulse, count stays 3.
3. Exit and underflow: from count=1, apply `ab` 00→01→11→10→00 → `car_out` pulse, count=0, empty=1. Repeat → `reject` pulse, count stays 0.
4. Abort, glitch and invalid input:
   - 10→11→10→00 (backed out) → no pulse, count unchanged.
   - A 2-cycle pulse on `sens_a` → ignored.
   - IDLE on 11 then 00 → WAIT_CLR then IDLE, no count change.
5. Two digits: `CAPACITY`=20, 12 entries → count=12, seg1=1111001, seg0=0100100, with seg updated one cycle after `count`. Then 3 exits → count=9, seg1=1111111, seg0=0010000.
6. Reset mid-sequence: assert `rst_n`=0 while in EN_AB with count=2 → outputs return to reset values immediately. After release, a fresh full entry → count=1.
